// File: rtl/enoc_input_unit.sv
// Router input-port buffer: circular flit FIFO with XY route computation on the head flit
// and a one-hot output-port request toward the switch controller.
module enoc_input_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_NODES    = 4,
  parameter int unsigned Y_NODES    = 4,
  parameter int unsigned X_LOC      = 0,
  parameter int unsigned Y_LOC      = 0,
  parameter int unsigned PIPE_SA    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_val,
  output logic                  o_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [4:0]            o_output_req,
  input  logic                  i_grant,
  output logic                  o_error
);

  localparam int unsigned X_W   = (X_NODES > 1) ? $clog2(X_NODES) : 1;
  localparam int unsigned Y_W   = (Y_NODES > 1) ? $clog2(Y_NODES) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PtrMax = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);
  localparam logic [X_W-1:0]   XLoc   = X_W'(X_LOC);
  localparam logic [Y_W-1:0]   YLoc   = Y_W'(Y_LOC);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  empty, full, wr_en, pop;
  logic [DATA_WIDTH-1:0] head;
  logic [X_W-1:0]        dest_x;
  logic [Y_W-1:0]        dest_y;
  logic [4:0]            route;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntMax);
  assign o_en  = ce && !reset && !full;
  assign wr_en = o_en && i_data_val;
  assign pop   = ce && i_grant && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
    end
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !wr_en) begin
      count_d = count_q - 1'b1;
    end
    // Overflow write or grant on empty are both sticky protocol violations.
    err_d = err_q || (ce && i_data_val && full) || (ce && i_grant && empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign head   = mem_q[rd_ptr_q];
  assign dest_x = head[X_W-1:0];
  assign dest_y = head[X_W+Y_W-1:X_W];

  // XY routing: resolve x first, then y; request bits are [c,n,e,s,w].
  always_comb begin
    route = '0;
    if (dest_x > XLoc) begin
      route[2] = 1'b1;
    end else if (dest_x < XLoc) begin
      route[4] = 1'b1;
    end else if (dest_y < YLoc) begin
      route[1] = 1'b1;
    end else if (dest_y > YLoc) begin
      route[3] = 1'b1;
    end else begin
      route[0] = 1'b1;
    end
  end

  // With registered grants the head being granted is stale; mask it so it cannot win twice.
  always_comb begin
    o_output_req = '0;
    if (!empty && ce && !((PIPE_SA != 0) && i_grant)) begin
      o_output_req = route;
    end
  end

  assign o_data  = empty ? '0 : head;
  assign o_error = err_q;

endmodule

// File: tb/tb_enoc_input_unit.sv
// Self-checking bench: two instances (PIPE_SA=0/1) share stimulus and are compared each cycle
// against a queue-based reference model, plus table-driven routing and directed corner cases.
module tb_enoc_input_unit;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset, ce, val, grant;
  logic [DW-1:0] data;
  logic          en0, en1, err0, err1;
  logic [DW-1:0] dout0, dout1;
  logic [4:0]    req0, req1;

  int checks = 0;
  int errors = 0;

  // Reference model: stored flits in arrival order, and the sticky error bit.
  int unsigned q[$];
  bit          m_err;

  always #5 clk = ~clk;

  enoc_input_unit #(
    .DATA_WIDTH(DW), .DEPTH(4), .X_NODES(4), .Y_NODES(4),
    .X_LOC(1), .Y_LOC(1), .PIPE_SA(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .ce(ce), .i_data(data), .i_data_val(val),
    .o_en(en0), .o_data(dout0), .o_output_req(req0), .i_grant(grant), .o_error(err0)
  );

  enoc_input_unit #(
    .DATA_WIDTH(DW), .DEPTH(4), .X_NODES(4), .Y_NODES(4),
    .X_LOC(1), .Y_LOC(1), .PIPE_SA(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .ce(ce), .i_data(data), .i_data_val(val),
    .o_en(en1), .o_data(dout1), .o_output_req(req1), .i_grant(grant), .o_error(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] route_of(input int unsigned d);
    int unsigned dx, dy;
    dx = d % 4;
    dy = (d / 4) % 4;
    if (dx > 1) return 5'b00100;
    if (dx < 1) return 5'b10000;
    if (dy < 1) return 5'b00010;
    if (dy > 1) return 5'b01000;
    return 5'b00001;
  endfunction

  function automatic logic [31:0] mkflit(input int unsigned dx, input int unsigned dy);
    logic [31:0] r;
    r = $urandom();
    return (r & 32'hFFFF_FFF0) | 32'(dy << 2) | 32'(dx);
  endfunction

  task automatic check_outputs();
    logic        e_en;
    logic [31:0] e_data;
    logic [4:0]  e_req;
    e_en   = ce && !reset && (q.size() < 4);
    e_data = (q.size() != 0) ? q[0] : 32'h0;
    e_req  = (q.size() != 0 && ce) ? route_of(q[0]) : 5'b0;
    chk("en0", 32'(en0), 32'(e_en));
    chk("en1", 32'(en1), 32'(e_en));
    chk("data0", dout0, e_data);
    chk("data1", dout1, e_data);
    chk("req0", 32'(req0), 32'(e_req));
    chk("req1", 32'(req1), grant ? 32'h0 : 32'(e_req));
    chk("err0", 32'(err0), 32'(m_err));
    chk("err1", 32'(err1), 32'(m_err));
  endtask

  task automatic model_update();
    int sz;
    sz = q.size();
    if (reset) begin
      q.delete();
      m_err = 1'b0;
    end else if (ce) begin
      if (val && sz == 4) m_err = 1'b1;
      if (grant && sz == 0) m_err = 1'b1;
      if (grant && sz != 0) void'(q.pop_front());
      if (val && sz < 4) q.push_back(data);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set(input logic r, input logic c, input logic v, input logic g,
                     input logic [31:0] d);
    reset = r; ce = c; val = v; grant = g; data = d;
  endtask

  task automatic do_reset();
    set(1, 1, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    int unsigned dx;
    int unsigned dy;
    logic [4:0]  req;
  } route_vec_t;

  route_vec_t tbl[6];
  logic [31:0] saved;

  initial begin
    tbl[0] = '{dx: 0, dy: 2, req: 5'b10000};
    tbl[1] = '{dx: 1, dy: 0, req: 5'b00010};
    tbl[2] = '{dx: 1, dy: 2, req: 5'b01000};
    tbl[3] = '{dx: 1, dy: 1, req: 5'b00001};
    tbl[4] = '{dx: 3, dy: 1, req: 5'b00100};
    tbl[5] = '{dx: 2, dy: 3, req: 5'b00100};
    m_err = 1'b0;

    set(1, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    tick();
    tick();
    #1;
    chk("reset_en", 32'(en0), 32'h0);

    // Single flit east, then one grant drains it.
    set(0, 1, 1, 0, mkflit(3, 1));
    tick();
    val = 1'b0;
    #1;
    chk("single_req_e", 32'(req0), 32'h04);
    grant = 1'b1;
    #1;
    chk("single_req_pipe_masked", 32'(req1), 32'h0);
    tick();
    grant = 1'b0;
    #1;
    chk("single_req_after", 32'(req0), 32'h0);
    chk("single_en_after", 32'(en0), 32'h1);
    tick();

    // Routing table sweep.
    for (int i = 0; i < 6; i++) begin
      set(0, 1, 1, 0, mkflit(tbl[i].dx, tbl[i].dy));
      tick();
      val = 1'b0;
      #1;
      chk($sformatf("route_%0d", i), 32'(req0), 32'(tbl[i].req));
      grant = 1'b1;
      tick();
      grant = 1'b0;
    end
    tick();

    // Fill to full, overflow write is dropped and flags error; one pop reopens the port.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set(0, 1, 1, 0, mkflit($urandom_range(3), $urandom_range(3)));
      tick();
    end
    val = 1'b0;
    #1;
    chk("full_en_low", 32'(en0), 32'h0);
    set(0, 1, 1, 0, 32'hDEAD_BEE5);
    tick();
    val = 1'b0;
    #1;
    chk("overflow_err", 32'(err0), 32'h1);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    #1;
    chk("pop_from_full_en", 32'(en0), 32'h1);
    grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dropped_never_seen", 32'(dout0 == 32'hDEAD_BEE5), 32'h0);
      tick();
    end
    grant = 1'b0;
    tick();

    // Full duplex across pointer wrap: write and pop every cycle.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set(0, 1, 1, 0, $urandom());
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      set(0, 1, 1, 1, $urandom());
      tick();
      #1;
      chk("duplex_en", 32'(en0), 32'h1);
    end
    set(0, 1, 0, 1, 0);
    tick();
    tick();
    grant = 1'b0;
    #1;
    chk("duplex_drained", dout0, 32'h0);
    tick();

    // Registered-grant variant: request masked in grant cycle, next head follows, no double pop.
    do_reset();
    set(0, 1, 1, 0, mkflit(3, 1));
    tick();
    data = mkflit(0, 1);
    tick();
    set(0, 1, 0, 1, 0);
    #1;
    chk("pipe_req_grant_cycle", 32'(req1), 32'h0);
    chk("nopipe_req_grant_cycle", 32'(req0), 32'h04);
    tick();
    grant = 1'b0;
    #1;
    chk("pipe_req_next", 32'(req1), 32'h10);
    tick();
    #1;
    chk("pipe_no_double_pop", 32'(req1), 32'h10);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    #1;
    chk("pipe_empty_req", 32'(req1), 32'h0);
    chk("pipe_empty_data", dout1, 32'h0);
    tick();

    // Clock enable low freezes everything; then reset mid-fill discards the buffer.
    do_reset();
    saved = $urandom();
    set(0, 1, 1, 0, saved);
    tick();
    data = $urandom();
    tick();
    for (int i = 0; i < 3; i++) begin
      set(0, 0, 1, 1, $urandom());
      #1;
      chk("ce_off_en", 32'(en0), 32'h0);
      chk("ce_off_req", 32'(req0), 32'h0);
      tick();
    end
    set(0, 1, 0, 0, 0);
    #1;
    chk("ce_off_err", 32'(err0), 32'h0);
    chk("ce_off_head", dout0, saved);
    set(0, 1, 1, 0, $urandom());
    tick();
    set(1, 1, 1, 0, $urandom());
    tick();
    set(0, 1, 0, 0, 0);
    #1;
    chk("midreset_req", 32'(req0), 32'h0);
    chk("midreset_en", 32'(en0), 32'h1);
    chk("midreset_data", dout0, 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set(($urandom_range(49) == 0), ($urandom_range(9) != 0), ($urandom_range(9) < 6),
          ($urandom_range(1) == 1), $urandom());
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enoc_input_unit.md
# enoc_input_unit

- Router input port buffer: sits between an upstream link and the crossbar switch controller.
- Accepts flits under valid/enable flow control and stores them in a circular FIFO.
- Computes the XY-routed output port of the head flit and presents it as a one-hot output request.
- Dequeues the head flit when the switch controller grants this input.

## Interface
Parameters:
- DATA_WIDTH, 32: flit width in bits; destination fields sit in the low bits.
- DEPTH, 4: FIFO entries, ≥2, need not be a power of two.
- X_NODES, 4: mesh width; X_W = max(1, clog2(X_NODES)).
- Y_NODES, 4: mesh height; Y_W = max(1, clog2(Y_NODES)).
- X_LOC, 0: this router's x coordinate.
- Y_LOC, 0: this router's y coordinate.
- PIPE_SA, 0: 1 when the switch controller registers its grants (grant arrives one cycle after the request).

Ports:
- clk  input  1  clock; one clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- ce  input  1  clock enable.
- i_data  input  DATA_WIDTH  flit from upstream; dest_x = i_data[X_W-1:0], dest_y = i_data[X_W+Y_W-1:X_W].
- i_data_val  input  1  upstream flit valid.
- o_en  output  1  enable to upstream; a flit may be presented only in a cycle where o_en=1.
- o_data  output  DATA_WIDTH  head flit to crossbar.
- o_output_req  output  5  one-hot request, bit order [c,n,e,s,w] = [0..4].
- i_grant  input  1  this input's grant from the switch controller (OR of its grant column).
- o_error  output  1  sticky protocol-violation flag.

## Operation
- State:
  - wr_ptr and rd_ptr, each 0..DEPTH-1; wrap from DEPTH-1 to 0.
  - count, 0..DEPTH, width clog2(DEPTH+1).
  - err register.
- Write: accepted when ce && i_data_val && o_en. Stores into mem[wr_ptr] and advances wr_ptr.
- Pop: occurs when ce && i_grant && count!=0. Advances rd_ptr.
- count update:
  - +1 on write only.
  - −1 on pop only.
  - Unchanged on simultaneous write and pop, including count==DEPTH−1. At count==DEPTH no write is possible.
- o_en:
  - Combinational: ce && !reset && count<DEPTH.
  - Write attempted while o_en=0 (i_data_val && ce && count==DEPTH): flit dropped and err set.
- i_grant while count==0: ignored, err set.
- o_error: reflects err; cleared only by reset.
- Routing, combinational from the head flit (mem[rd_ptr]):
  - dest_x > X_LOC → e.
  - dest_x < X_LOC → w.
  - Otherwise dest_y < Y_LOC → n.
  - Otherwise dest_y > Y_LOC → s.
  - Otherwise c.
- o_output_req = route one-hot when count!=0 && ce, else 0.
- PIPE_SA=1: o_output_req is forced to 0 in any cycle where i_grant=1. This prevents the stale head from re-requesting and earning a second grant.
- o_data = mem[rd_ptr] when count!=0, else 0.
- ce=0: all state frozen; o_en=0; o_output_req=0; writes and grants are ignored and do not set err.
- Reset: count=0, wr_ptr=0, rd_ptr=0, err=0. Memory contents need no reset. Reset mid-operation discards all stored flits.

## Timing
- Reset values:
  - o_en=0 while reset=1; 1 in the first cycle after release (if ce=1).
  - o_output_req=0, o_data=0, o_error=0.
- Write latency: flit written at edge t is visible on o_data/o_output_req in cycle t+1 (empty buffer).
- o_en falls in the cycle after the write that makes count==DEPTH. It rises in the cycle after a pop from full.
- Pop: head advances at the edge where i_grant=1. The next flit's request appears in the following cycle.
- PIPE_SA=0: back-to-back pops each cycle allowed. Sustained throughput is 1 flit/cycle with simultaneous write and pop.
- PIPE_SA=1: request drops for exactly the grant cycle. Maximum rate is one grant per two cycles per input.
- o_error: rises in the cycle after the violating edge.

## Test plan
- Reset then single flit: X_LOC=1, Y_LOC=1, write dest (x=3,y=1) → next cycle o_output_req=5'b00100 (e). Assert i_grant one cycle → req=0, count=0.
- Routing sweep with X_LOC=1, Y_LOC=1:
  - dest (0,2) → w.
  - (1,0) → n.
  - (1,2) → s.
  - (1,1) → c.
- Fill DEPTH=4 with no grants → o_en=0 after the 4th write. 5th i_data_val → o_error=1 and the dropped flit never appears at o_data. Grant once → o_en=1 the next cycle.
- Full duplex: continuous writes with i_grant held high, PIPE_SA=0 → count stays constant, output order equals input order across pointer wrap (≥10 flits).
- PIPE_SA=1 with two queued flits to different ports: grant at t → o_output_req=0 in cycle t. Second flit's request appears at t+1 and no double pop occurs.
- ce=0 for 3 cycles with i_data_val=1 and i_grant=1 → count unchanged, o_en=0, o_error=0. Assert reset mid-fill → count=0 and o_output_req=0 the next cycle.
